// File: rtl/spi_master_core.sv
// ---------------------------------------------------------------------------
// spi_master_core
//
// Parametrised SPI master.  A CPU-style strobe (cs/wr with rd low) loads a
// word and starts one transfer.  SCLK polarity and phase are chosen per
// transfer.  The word received on miso is presented on dout once the
// transfer has finished.
//
// Parameters
//   DWIDTH    bits per transfer (>= 2)
//   CLKDIV    clk cycles per SCLK half-period (>= 1)
//   LSB_FIRST 0: MSB shifted first, 1: LSB shifted first (TX and RX)
//
// Ports
//   clk, rst    system clock, synchronous active-high reset
//   cs, rd, wr  register strobes; cs & wr & ~rd in IDLE starts a transfer
//   din         word to transmit
//   cpol, cpha  SPI mode, captured when the transfer starts
//   dout        last received word (updated only at completion)
//   miso        serial input from the slave
//   mosi, sclk  serial output and SPI clock (registered)
//   ss_n        active-low slave select (registered)
//   busy        high while a transfer is in progress
//   done        sticky completion flag, cleared by the next start or reset
// ---------------------------------------------------------------------------
module spi_master_core #(
    parameter int DWIDTH    = 8,
    parameter int CLKDIV    = 2,
    parameter int LSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              rd,
    input  logic              wr,
    input  logic [DWIDTH-1:0] din,
    input  logic              cpol,
    input  logic              cpha,
    output logic [DWIDTH-1:0] dout,
    input  logic              miso,
    output logic              mosi,
    output logic              sclk,
    output logic              ss_n,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam int DIV_W  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int EDGE_W = $clog2(2 * DWIDTH + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLKDIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DWIDTH - 1);

    logic [1:0]        state;
    logic [DIV_W-1:0]  div_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic [DWIDTH-1:0] tx_sr;
    logic [DWIDTH-1:0] rx_sr;
    logic              cpha_q;

    logic              start;
    logic              div_tc;
    logic              last_edge;
    logic              sample_now;
    logic [DWIDTH-1:0] rx_next;

    // Bit that leaves the shift register first for the configured order.
    function automatic logic first_bit(input logic [DWIDTH-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[DWIDTH-1];
    endfunction

    // Shift register after one bit has been sent.
    function automatic logic [DWIDTH-1:0] shift_out(input logic [DWIDTH-1:0] w);
        return (LSB_FIRST != 0) ? {1'b0, w[DWIDTH-1:1]} : {w[DWIDTH-2:0], 1'b0};
    endfunction

    assign start     = (state == ST_IDLE) && cs && wr && !rd && !busy;
    assign div_tc    = (div_cnt == DIV_LAST);
    assign last_edge = (edge_cnt == EDGE_LAST);

    // edge_cnt holds the number of edges already produced, so the edge
    // about to be produced is a leading edge when edge_cnt is even.
    // cpha=0 samples on leading edges, cpha=1 on trailing edges.
    assign sample_now = (~edge_cnt[0]) ^ cpha_q;

    assign rx_next = (LSB_FIRST != 0) ? {miso, rx_sr[DWIDTH-1:1]}
                                      : {rx_sr[DWIDTH-2:0], miso};

    // The sclk register itself carries the latched polarity: it is loaded
    // with cpol at the start and only toggles during SHIFT, so after an even
    // number of edges it is back at the captured cpol.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            cpha_q   <= 1'b0;
            dout     <= '0;
            mosi     <= 1'b0;
            sclk     <= 1'b0;
            ss_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sclk <= cpol;
                    mosi <= 1'b0;
                    ss_n <= 1'b1;
                    if (start) begin
                        state    <= ST_SHIFT;
                        cpha_q   <= cpha;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        ss_n     <= 1'b0;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                        rx_sr    <= '0;
                        // cpha=0 presents the first bit before any edge;
                        // cpha=1 waits for the first leading edge.
                        if (cpha) begin
                            tx_sr <= din;
                        end else begin
                            mosi  <= first_bit(din);
                            tx_sr <= shift_out(din);
                        end
                    end
                end

                ST_SHIFT: begin
                    if (div_tc) begin
                        div_cnt  <= '0;
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + EDGE_W'(1);
                        if (sample_now) begin
                            rx_sr <= rx_next;
                        end else if (!last_edge) begin
                            mosi  <= first_bit(tx_sr);
                            tx_sr <= shift_out(tx_sr);
                        end
                        if (last_edge) begin
                            state <= ST_HOLD;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                ST_HOLD: begin
                    // One extra half-period keeps ss_n low after the last edge.
                    if (div_tc) begin
                        state   <= ST_IDLE;
                        div_cnt <= '0;
                        ss_n    <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        dout    <= rx_sr;
                        mosi    <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_core.sv
// ---------------------------------------------------------------------------
// tb_spi_master_core
//
// Two instances share one set of strobes: dut_a (8 bit, CLKDIV=2, MSB first)
// and dut_b (16 bit, CLKDIV=1, LSB first).  'sel' chooses which one receives
// wr and which one is observed.  A timeline model derives every output from
// the cycle distance to the start edge; an edge-driven slave serves miso
// when loopback is off and records what it receives on mosi.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
    logic        cpol = 1'b0, cpha = 1'b0;
    logic [15:0] din = '0;
    logic        loop = 1'b1;
    logic [15:0] slave_word = '0;
    logic        slave_miso = 1'b0;
    logic        sel = 1'b0;

    logic [7:0]  dout_a;
    logic        mosi_a, sclk_a, ss_n_a, busy_a, done_a, miso_a, wr_a;
    logic [15:0] dout_b;
    logic        mosi_b, sclk_b, ss_n_b, busy_b, done_b, miso_b, wr_b;

    logic [15:0] o_dout;
    logic        o_mosi, o_sclk, o_ss_n, o_busy, o_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model state
    logic        m_init = 1'b0, m_active = 1'b0;
    int          m_e0 = 0;
    logic [15:0] m_d = '0, m_rx = '0, m_dout = '0;
    logic        m_cpol = 1'b0, m_cpha = 1'b0, m_done = 1'b0, m_sclk_idle = 1'b0;

    // slave and monitor state
    logic        sl_on = 1'b0, sl_prev = 1'b0;
    int          sl_tx = 0, sl_rx_n = 0;
    logic [15:0] sl_rxw = '0;
    int          ss_low_cnt = 0, rise_cnt = 0;
    logic        mon_prev_sclk = 1'b0;

    always #5 clk = ~clk;

    assign wr_a   = wr & ~sel;
    assign wr_b   = wr & sel;
    assign miso_a = loop ? mosi_a : slave_miso;
    assign miso_b = loop ? mosi_b : slave_miso;

    assign o_dout = sel ? dout_b : {8'h00, dout_a};
    assign o_mosi = sel ? mosi_b : mosi_a;
    assign o_sclk = sel ? sclk_b : sclk_a;
    assign o_ss_n = sel ? ss_n_b : ss_n_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;

    spi_master_core #(.DWIDTH(8), .CLKDIV(2), .LSB_FIRST(0)) dut_a (
        .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr_a), .din(din[7:0]),
        .cpol(cpol), .cpha(cpha), .dout(dout_a), .miso(miso_a), .mosi(mosi_a),
        .sclk(sclk_a), .ss_n(ss_n_a), .busy(busy_a), .done(done_a)
    );

    spi_master_core #(.DWIDTH(16), .CLKDIV(1), .LSB_FIRST(1)) dut_b (
        .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr_b), .din(din),
        .cpol(cpol), .cpha(cpha), .dout(dout_b), .miso(miso_b), .mosi(mosi_b),
        .sclk(sclk_b), .ss_n(ss_n_b), .busy(busy_b), .done(done_b)
    );

    function automatic int cur_dw();
        return sel ? 16 : 8;
    endfunction

    function automatic int cur_ck();
        return sel ? 1 : 2;
    endfunction

    function automatic logic [15:0] cur_mask();
        return sel ? 16'hFFFF : 16'h00FF;
    endfunction

    // i-th bit on the wire (i = 0 is sent first) for the observed instance.
    function automatic logic bitof(input logic [15:0] w, input int i);
        int dw;
        dw = cur_dw();
        return sel ? w[i] : w[dw-1-i];
    endfunction

    // Compare one value, count it, and report a failure on a single line.
    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cyc %0d: got %h, want %h", name, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse a start strobe; the following rising edge is the start edge E0.
    task automatic applyStimulus(input logic [15:0] d, input logic pol, input logic pha);
        cs   = 1'b1;
        wr   = 1'b1;
        rd   = 1'b0;
        din  = d;
        cpol = pol;
        cpha = pha;
        tick();
        cs = 1'b0;
        wr = 1'b0;
    endtask

    // Wait (bounded) for done; dc is the cycle whose edge raised it.
    task automatic wait_done(output int dc);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_done === 1'b1) break;
        end
        dc = cyc;
        checkOutput("done_wait", {15'd0, o_done}, 16'd1);
    endtask

    // Reset both instances so the single model starts clean, then switch.
    task automatic switch_dut(input logic s);
        rst = 1'b1;
        tick();
        sel = s;
        tick();
        rst = 1'b0;
    endtask

    // Timeline model: at every rising edge decide completion or start from
    // the strobes and the cycle distance to E0.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_init      = 1'b1;
            m_active    = 1'b0;
            m_done      = 1'b0;
            m_dout      = '0;
            m_sclk_idle = 1'b0;
        end else if (m_active) begin
            if (cyc - m_e0 == (2 * cur_dw() + 1) * cur_ck()) begin
                m_active = 1'b0;
                m_done   = 1'b1;
                m_dout   = m_rx;
            end
        end else begin
            m_sclk_idle = cpol;
            if (cs && wr && !rd) begin
                m_active = 1'b1;
                m_e0     = cyc;
                m_done   = 1'b0;
                m_d      = din & cur_mask();
                m_cpol   = cpol;
                m_cpha   = cpha;
                m_rx     = (loop ? din : slave_word) & cur_mask();
            end
        end
    end

    // Per-cycle comparison of every output against the timeline model.
    // After t cycles from E0, n = t / CLKDIV edges have been produced.
    always @(negedge clk) begin
        logic e_ss, e_busy, e_done, e_sclk, e_mosi;
        int   t, n, idx;
        if (m_init) begin
            if (m_active) begin
                t      = cyc - m_e0;
                n      = t / cur_ck();
                if (n > 2 * cur_dw()) n = 2 * cur_dw();
                e_ss   = 1'b0;
                e_busy = 1'b1;
                e_done = 1'b0;
                e_sclk = m_cpol ^ ((n % 2) == 1);
                if (m_cpha) begin
                    e_mosi = (n == 0) ? 1'b0 : bitof(m_d, (n - 1) / 2);
                end else begin
                    idx    = (n / 2 > cur_dw() - 1) ? cur_dw() - 1 : n / 2;
                    e_mosi = bitof(m_d, idx);
                end
            end else begin
                e_ss   = 1'b1;
                e_busy = 1'b0;
                e_done = m_done;
                e_sclk = m_sclk_idle;
                e_mosi = 1'b0;
            end
            checkOutput("ss_n", {15'd0, o_ss_n}, {15'd0, e_ss});
            checkOutput("busy", {15'd0, o_busy}, {15'd0, e_busy});
            checkOutput("done", {15'd0, o_done}, {15'd0, e_done});
            checkOutput("sclk", {15'd0, o_sclk}, {15'd0, e_sclk});
            checkOutput("mosi", {15'd0, o_mosi}, {15'd0, e_mosi});
            checkOutput("dout", o_dout, m_dout);
        end
        if (o_ss_n === 1'b0) ss_low_cnt++;
        if (o_sclk === 1'b1 && mon_prev_sclk === 1'b0) rise_cnt++;
        mon_prev_sclk = o_sclk;
    end

    // Edge-driven slave: presents slave_word on miso and records mosi,
    // reacting to sclk transitions it sees on the wire.
    always @(negedge clk) begin
        logic lead;
        if (o_ss_n !== 1'b0) begin
            sl_on      = 1'b0;
            sl_tx      = 0;
            sl_rx_n    = 0;
            slave_miso = 1'b0;
        end else if (!sl_on) begin
            sl_on   = 1'b1;
            sl_prev = o_sclk;
            sl_rxw  = '0;
            if (!m_cpha) begin
                slave_miso = bitof(slave_word, 0);
                sl_tx      = 1;
            end
        end else if (o_sclk != sl_prev) begin
            lead = (o_sclk != m_cpol);
            if (lead != m_cpha) begin
                if (sl_rx_n < cur_dw()) begin
                    sl_rxw[sel ? sl_rx_n : cur_dw() - 1 - sl_rx_n] = o_mosi;
                    sl_rx_n++;
                end
            end else if (sl_tx < cur_dw()) begin
                slave_miso = bitof(slave_word, sl_tx);
                sl_tx++;
            end
            sl_prev = o_sclk;
        end
    end

    // Directed scenarios first, then randomized transfers on both instances.
    initial begin
        int          dc, e0, len;
        logic [15:0] d;
        logic        pol, pha;

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_ss_n", {15'd0, o_ss_n}, 16'd1);
        checkOutput("rst_busy", {15'd0, o_busy}, 16'd0);
        checkOutput("rst_dout", o_dout, 16'h0000);
        checkOutput("rst_sclk", {15'd0, o_sclk}, 16'd0);

        // mode 0 loopback 0xA5
        $display("[TB] mode 0 loopback");
        loop = 1'b1;
        tick();
        ss_low_cnt = 0;
        rise_cnt   = 0;
        applyStimulus(16'h00A5, 1'b0, 1'b0);
        e0 = m_e0;
        wait_done(dc);
        checkOutput("t1_len", 16'(dc - e0), 16'd34);
        checkOutput("t1_dout", o_dout, 16'h00A5);
        checkOutput("t1_rises", 16'(rise_cnt), 16'd8);
        checkOutput("t1_ss_low", 16'(ss_low_cnt), 16'd34);
        tick();
        @(negedge clk);
        checkOutput("t1_idle_sclk", {15'd0, o_sclk}, 16'd0);

        // mode 3 with slave returning 0x3C
        $display("[TB] mode 3 slave");
        loop       = 1'b0;
        slave_word = 16'h003C;
        cpol       = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checkOutput("t2_idle_pre", {15'd0, o_sclk}, 16'd1);
        applyStimulus(16'h00C3, 1'b1, 1'b1);
        wait_done(dc);
        checkOutput("t2_dout", o_dout, 16'h003C);
        checkOutput("t2_slave_rx", sl_rxw, 16'h00C3);
        tick();
        @(negedge clk);
        checkOutput("t2_idle_post", {15'd0, o_sclk}, 16'd1);

        // writes ignored while busy, rd=wr=1 ignored while idle
        $display("[TB] ignored strobes");
        loop = 1'b1;
        applyStimulus(16'h0096, 1'b0, 1'b0);
        e0 = m_e0;
        repeat (4) tick();
        cs = 1'b1; wr = 1'b1; din = 16'h0011; cpol = 1'b1; cpha = 1'b1;
        tick();
        cs = 1'b0; wr = 1'b0; cpol = 1'b0; cpha = 1'b0;
        wait_done(dc);
        checkOutput("t3_len", 16'(dc - e0), 16'd34);
        checkOutput("t3_dout", o_dout, 16'h0096);
        tick();
        cs = 1'b1; rd = 1'b1; wr = 1'b1; din = 16'h0077;
        repeat (3) tick();
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        checkOutput("t3_rdwr_busy", {15'd0, o_busy}, 16'd0);
        checkOutput("t3_rdwr_done", {15'd0, o_done}, 16'd1);

        // reset at edge 7
        $display("[TB] reset mid transfer");
        applyStimulus(16'h00F0, 1'b0, 1'b0);
        repeat (13) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t4_ss_n", {15'd0, o_ss_n}, 16'd1);
        checkOutput("t4_sclk", {15'd0, o_sclk}, 16'd0);
        checkOutput("t4_busy", {15'd0, o_busy}, 16'd0);
        checkOutput("t4_done", {15'd0, o_done}, 16'd0);
        checkOutput("t4_dout", o_dout, 16'h0000);
        tick();
        applyStimulus(16'h005A, 1'b0, 1'b0);
        wait_done(dc);
        checkOutput("t4_dout2", o_dout, 16'h005A);

        // 16 bit LSB-first, CLKDIV=1
        $display("[TB] 16 bit lsb first");
        switch_dut(1'b1);
        loop = 1'b1;
        applyStimulus(16'h8001, 1'b0, 1'b0);
        e0 = m_e0;
        @(negedge clk);
        checkOutput("t5_first", {15'd0, o_mosi}, 16'd1);
        repeat (2) @(negedge clk);
        checkOutput("t5_bit1", {15'd0, o_mosi}, 16'd0);
        repeat (28) @(negedge clk);
        checkOutput("t5_bit15", {15'd0, o_mosi}, 16'd1);
        wait_done(dc);
        checkOutput("t5_len", 16'(dc - e0), 16'd33);
        checkOutput("t5_dout", o_dout, 16'h8001);

        // back-to-back
        $display("[TB] back to back");
        applyStimulus(16'h1234, 1'b0, 1'b0);
        wait_done(dc);
        cs = 1'b1; wr = 1'b1; din = 16'hBEEF;
        checkOutput("t6_gap_ss_n", {15'd0, o_ss_n}, 16'd1);
        @(posedge clk);
        #1;
        cs = 1'b0; wr = 1'b0;
        @(negedge clk);
        checkOutput("t6_restart_ss_n", {15'd0, o_ss_n}, 16'd0);
        checkOutput("t6_restart_done", {15'd0, o_done}, 16'd0);
        wait_done(dc);
        checkOutput("t6_dout", o_dout, 16'hBEEF);

        // randomized transfers with strobe noise on both instances
        $display("[TB] random transfers");
        for (int s = 0; s < 2; s++) begin
            switch_dut(s[0]);
            for (int k = 0; k < 20; k++) begin
                loop       = 1'($urandom_range(0, 1));
                slave_word = 16'($urandom);
                repeat ($urandom_range(0, 3)) begin
                    cs   = 1'($urandom_range(0, 1));
                    rd   = 1'($urandom_range(0, 1));
                    wr   = rd ? 1'($urandom_range(0, 1)) : 1'b0;
                    cpol = 1'($urandom_range(0, 1));
                    tick();
                end
                cs = 1'b0; rd = 1'b0; wr = 1'b0;
                d   = 16'($urandom);
                pol = 1'($urandom_range(0, 1));
                pha = 1'($urandom_range(0, 1));
                applyStimulus(d, pol, pha);
                len = (2 * cur_dw() + 1) * cur_ck();
                for (int j = 0; j < len - 3; j++) begin
                    cs   = 1'($urandom_range(0, 1));
                    rd   = 1'($urandom_range(0, 1));
                    wr   = 1'($urandom_range(0, 1));
                    din  = 16'($urandom);
                    cpol = 1'($urandom_range(0, 1));
                    cpha = 1'($urandom_range(0, 1));
                    tick();
                end
                cs = 1'b0; rd = 1'b0; wr = 1'b0;
                wait_done(dc);
                checkOutput("rnd_slave_rx", sl_rxw, d & cur_mask());
            end
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("[TB] FAIL watchdog at cyc %0d: got timeout, want completion", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
